// File: rtl/bp_reg_bank.sv
// rtl/bp_reg_bank.sv - byte-pipe register bank with read-only inputs and masked read-write registers
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rstn       asynchronous active-low reset
//   i_cg         clock-gate enable; low freezes all state and blocks handshakes
//   i_ro         live read-only values, byte j returned at address j
//   o_rw         current read-write register values, byte k is register k
//   o_wrStrobe   one-cycle pulse per register, the cycle after it is written
//   i_bp_data/i_bp_valid/o_bp_ready   request stream (command byte, optional data byte)
//   o_bp_data/o_bp_valid/i_bp_ready   response stream (one byte per transaction)

module bp_reg_bank #(
  parameter int                N_RO     = 7,
  parameter int                N_RW     = 6,
  parameter logic [8*N_RW-1:0] RW_RESET = '0,
  parameter logic [8*N_RW-1:0] RW_MASK  = '1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cg,
  input  logic [8*N_RO-1:0] i_ro,
  output logic [8*N_RW-1:0] o_rw,
  output logic [N_RW-1:0]   o_wrStrobe,
  input  logic [7:0]        i_bp_data,
  input  logic              i_bp_valid,
  output logic              o_bp_ready,
  output logic [7:0]        o_bp_data,
  output logic              o_bp_valid,
  input  logic              i_bp_ready
);

  typedef enum logic [1:0] {IDLE, WRDATA, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [6:0]          addr_q;
  logic [7:0]          resp_q;
  logic [8*N_RW-1:0]   rw_q;
  logic [N_RW-1:0]     strobe_q;

  logic                accept;
  logic                resp_done;
  logic [6:0]          cur_addr;
  logic [7:0]          rd_val;
  logic [7:0]          wr_resp;
  logic [8*N_RW-1:0]   wr_val;
  logic [N_RW-1:0]     wr_sel;

  // Handshakes only complete while the clock gate is open.
  assign accept    = i_cg & i_bp_valid & o_bp_ready;
  assign resp_done = i_cg & (state == RESP) & i_bp_ready;

  // In IDLE the address comes straight from the command byte being accepted;
  // in WRDATA it is the one latched from the preceding command.
  assign cur_addr = (state == IDLE) ? i_bp_data[6:0] : addr_q;

  // Read mux: RO window, then RW window, anything above reads as zero.
  always_comb begin
    rd_val = 8'h00;
    for (int j = 0; j < N_RO; j++) begin
      if (cur_addr == 7'(j)) rd_val = i_ro[j*8 +: 8];
    end
    for (int k = 0; k < N_RW; k++) begin
      if (cur_addr == 7'(N_RO + k)) rd_val = rw_q[k*8 +: 8];
    end
  end

  // Candidate masked write value for every RW register, and which one (if any)
  // is actually written this cycle. RO and out-of-range addresses select none.
  always_comb begin
    wr_val  = '0;
    wr_sel  = '0;
    wr_resp = rd_val;
    for (int k = 0; k < N_RW; k++) begin
      wr_val[k*8 +: 8] = (rw_q[k*8 +: 8] & ~RW_MASK[k*8 +: 8]) |
                         (i_bp_data & RW_MASK[k*8 +: 8]);
      if ((state == WRDATA) && accept && (addr_q == 7'(N_RO + k))) begin
        wr_sel[k] = 1'b1;
        wr_resp   = wr_val[k*8 +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = i_bp_data[7] ? WRDATA : RESP;
      WRDATA:  if (accept) state_nxt = RESP;
      RESP:    if (resp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_bp_ready = 1'b0;
    o_bp_valid = 1'b0;
    case (state)
      IDLE:    o_bp_ready = 1'b1;
      WRDATA:  o_bp_ready = 1'b1;
      RESP:    o_bp_valid = 1'b1;
      default: o_bp_ready = 1'b0;
    endcase
  end

  // Datapath: address/response latches, RW registers, write strobes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_q   <= '0;
      resp_q   <= '0;
      rw_q     <= RW_RESET;
      strobe_q <= '0;
    end else begin
      // Strobe is a pure pulse: it always self-clears, so a gated clock can
      // never stretch it past one cycle.
      strobe_q <= wr_sel;
      if (accept && (state == IDLE)) begin
        addr_q <= i_bp_data[6:0];
        if (!i_bp_data[7]) resp_q <= rd_val;
      end
      if (accept && (state == WRDATA)) begin
        resp_q <= wr_resp;
        for (int k = 0; k < N_RW; k++) begin
          if (wr_sel[k]) rw_q[k*8 +: 8] <= wr_val[k*8 +: 8];
        end
      end
    end
  end

  assign o_rw       = rw_q;
  assign o_wrStrobe = strobe_q;
  assign o_bp_data  = resp_q;

endmodule
